// File: rtl/entrada_fisica_debounce_pkg.sv
// Shared constants and helpers for the physical-input conditioner.
//   CLK_HZ           : board system clock frequency
//   CNT_MAX_DEFAULT  : stable cycles needed to accept a level (10 ms at CLK_HZ)
//   clog2()          : ceiling log2, used to size the per-channel counters
package entrada_fisica_debounce_pkg;

  localparam int CLK_HZ          = 50_000_000;
  localparam int CNT_MAX_DEFAULT = CLK_HZ / 100;

  function automatic int clog2(input longint unsigned value);
    int              bits;
    longint unsigned v;
    bits = 0;
    v    = value - 1;
    while (v > 0) begin
      bits = bits + 1;
      v    = v >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/entrada_fisica_debounce_if.sv
// Signal bundle between the board pins and the core.
//   raw_in  : raw pin levels, asynchronous to clk
//   level   : debounced, polarity-corrected level (1 = pressed/active)
//   rise    : one-cycle pulse when level goes 0->1
//   fall    : one-cycle pulse when level goes 1->0
//   changed : OR of every rise/fall bit in the same cycle
// master drives the pins and consumes the results; slave is the conditioner.
interface entrada_fisica_debounce_if #(
  parameter int N_IN = 4
);

  logic [N_IN-1:0] raw_in;
  logic [N_IN-1:0] level;
  logic [N_IN-1:0] rise;
  logic [N_IN-1:0] fall;
  logic            changed;

  modport master (output raw_in, input level, rise, fall, changed);
  modport slave  (input raw_in, output level, rise, fall, changed);

endinterface

// File: rtl/entrada_fisica_debounce_canal.sv
// One debounced input channel: two-flop synchroniser, polarity correction,
// stability counter, accepted level and registered edge pulses.
//   clk, rst_n : system clock, asynchronous active-low reset
//   raw        : raw pin level, asynchronous to clk
//   level      : accepted level (1 = active)
//   rise, fall : one-cycle pulses coincident with the first cycle of a new level
module debounce_canal
  import entrada_fisica_debounce_pkg::*;
#(
  parameter int CNT_MAX = CNT_MAX_DEFAULT,
  parameter bit INV     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int               CNT_W    = clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic             sync1;
  logic             sync2;
  logic             norm;
  logic [CNT_W-1:0] cnt;

  // Synchroniser resets to the pin's idle level so release never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= INV;
      sync2 <= INV;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  assign norm = sync2 ^ INV;

  // Any sample agreeing with the current level restarts the whole window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (norm == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= norm;
        rise  <= norm;
        fall  <= ~norm;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/entrada_fisica_debounce.sv
// Input-side conditioner for switches and push-buttons: N_IN independent
// debounced channels plus a combined "something changed" pulse.
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : slave side of entrada_fisica_debounce_if (raw_in in;
//                level, rise, fall, changed out)
// ACTIVE_LOW_MASK bit i set means pin i reads 0 when pressed.
module entrada_fisica_debounce
  import entrada_fisica_debounce_pkg::*;
#(
  parameter int              N_IN            = 4,
  parameter int              CNT_MAX         = CNT_MAX_DEFAULT,
  parameter logic [N_IN-1:0] ACTIVE_LOW_MASK = N_IN'(1)
) (
  input logic                        clk,
  input logic                        rst_n,
  entrada_fisica_debounce_if.slave   bus
);

  logic [N_IN-1:0] level_v;
  logic [N_IN-1:0] rise_v;
  logic [N_IN-1:0] fall_v;

  for (genvar i = 0; i < N_IN; i++) begin : g_canal
    debounce_canal #(
      .CNT_MAX (CNT_MAX),
      .INV     (ACTIVE_LOW_MASK[i])
    ) u_canal (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (bus.raw_in[i]),
      .level (level_v[i]),
      .rise  (rise_v[i]),
      .fall  (fall_v[i])
    );
  end

  assign bus.level   = level_v;
  assign bus.rise    = rise_v;
  assign bus.fall    = fall_v;
  assign bus.changed = |(rise_v | fall_v);

endmodule

// File: tb/tb_entrada_fisica_debounce.sv
module tb_entrada_fisica_debounce;

  localparam int         N    = 2;
  localparam int         CM   = 4;
  localparam logic [1:0] MASK = 2'b01;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  entrada_fisica_debounce_if #(.N_IN(N)) bus ();

  entrada_fisica_debounce #(
    .N_IN            (N),
    .CNT_MAX         (CM),
    .ACTIVE_LOW_MASK (MASK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the pin seen two edges late, polarity-corrected; a new
  // level is accepted when the last CM such samples all disagree with it.
  logic [1:0] rawq[$];
  logic [1:0] normq[$];
  logic [1:0] m_level;
  logic [1:0] m_rise;
  logic [1:0] m_fall;

  function automatic void model_reset();
    rawq.delete();
    normq.delete();
    m_level = 2'b00;
    m_rise  = 2'b00;
    m_fall  = 2'b00;
  endfunction

  function automatic void model_edge(input logic [1:0] raw);
    logic [1:0] norm;
    bit         accept;
    int         sz;
    norm = (rawq.size() >= 2) ? (rawq[rawq.size()-2] ^ MASK) : 2'b00;
    rawq.push_back(raw);
    normq.push_back(norm);
    m_rise = 2'b00;
    m_fall = 2'b00;
    sz = normq.size();
    for (int ch = 0; ch < N; ch++) begin
      if (sz >= CM) begin
        accept = 1'b1;
        for (int j = 0; j < CM; j++)
          if (normq[sz-1-j][ch] == m_level[ch]) accept = 1'b0;
        if (accept) begin
          m_level[ch] = norm[ch];
          if (norm[ch]) m_rise[ch] = 1'b1;
          else          m_fall[ch] = 1'b1;
        end
      end
    end
  endfunction

  // Drive raw, take one edge, compare all outputs against the model.
  task automatic tick(input logic [1:0] raw, input string name,
                      output logic [1:0] r, output logic [1:0] f);
    bus.raw_in = raw;
    @(posedge clk);
    model_edge(raw);
    #1;
    checks++;
    if ({bus.level, bus.rise, bus.fall, bus.changed} !==
        {m_level, m_rise, m_fall, |(m_rise | m_fall)}) begin
      errors++;
      $display("FAIL %s: got level=%b rise=%b fall=%b changed=%b, want level=%b rise=%b fall=%b changed=%b",
               name, bus.level, bus.rise, bus.fall, bus.changed,
               m_level, m_rise, m_fall, |(m_rise | m_fall));
    end
    r = bus.rise;
    f = bus.fall;
  endtask

  task automatic apply_reset();
    rst_n      = 1'b0;
    bus.raw_in = 2'b01;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [1:0] r, f;
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      tick(2'b01, "reset_idle", r, f);
      checks++;
      if ({bus.level, r, f, bus.changed} !== 7'b0) begin
        errors++;
        $display("FAIL reset_quiet: got %b want 0000000", {bus.level, r, f, bus.changed});
      end
    end
  endtask

  task automatic test_rise_ch1();
    logic [1:0] r, f;
    int first = -1, pulses = 0, falls = 0;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      tick(2'b11, "rise_ch1", r, f);
      if (r[1]) begin
        pulses++;
        if (first < 0) first = i;
      end
      if (f != 2'b00) falls++;
    end
    checks++;
    if (first != 5) begin errors++; $display("FAIL rise_ch1_latency: got %0d want 5", first); end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL rise_ch1_pulses: got %0d want 1", pulses); end
    checks++;
    if (falls != 0) begin errors++; $display("FAIL rise_ch1_fall: got %0d want 0", falls); end
  endtask

  task automatic test_active_low();
    logic [1:0] r, f;
    int first_r = -1, first_f = -1;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      tick(2'b00, "press_ch0", r, f);
      if (r[0] && first_r < 0) first_r = i;
    end
    for (int i = 0; i < 6; i++) begin
      tick(2'b01, "release_ch0", r, f);
      if (f[0] && first_f < 0) first_f = i;
    end
    checks++;
    if (first_r != 5) begin errors++; $display("FAIL press_ch0_latency: got %0d want 5", first_r); end
    checks++;
    if (first_f != 5) begin errors++; $display("FAIL release_ch0_latency: got %0d want 5", first_f); end
    checks++;
    if (bus.level !== 2'b00) begin errors++; $display("FAIL release_ch0_level: got %b want 00", bus.level); end
  endtask

  task automatic test_bounce();
    logic [1:0] r, f;
    logic [11:0] pat;
    int pulses = 0, first = -1;
    pat = 12'b0000_1110_1110 ;
    apply_reset();
    // pattern read LSB first with bit 0 skipped: 3 high, 1 low, 3 high, then low
    for (int i = 1; i < 12; i++) begin
      tick({pat[i], 1'b1}, "bounce", r, f);
      if ((r | f) != 2'b00) pulses++;
    end
    checks++;
    if (pulses != 0 || bus.level !== 2'b00) begin
      errors++;
      $display("FAIL bounce_reject: got pulses=%0d level=%b want 0 00", pulses, bus.level);
    end
    for (int i = 0; i < 8; i++) begin
      tick(2'b11, "bounce_hold", r, f);
      if (r[1] && first < 0) first = i;
    end
    checks++;
    if (first != 5) begin errors++; $display("FAIL bounce_full_window: got %0d want 5", first); end
  endtask

  task automatic test_simultaneous();
    logic [1:0] r, f;
    int both = -1, chg = 0;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      tick(2'b10, "simultaneous", r, f);
      if (r == 2'b11 && both < 0) both = i;
      if (bus.changed) chg++;
    end
    checks++;
    if (both != 5 || chg != 1) begin
      errors++;
      $display("FAIL simultaneous: got edge=%0d changed_cycles=%0d want 5 1", both, chg);
    end
  endtask

  task automatic test_async_reset();
    logic [1:0] r, f;
    int first = -1, pulses = 0;
    apply_reset();
    for (int i = 0; i < 6; i++) tick(2'b00, "pre_press", r, f);
    for (int i = 0; i < 3; i++) tick(2'b10, "mid_count", r, f);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({bus.level, bus.rise, bus.fall, bus.changed} !== 7'b0) begin
      errors++;
      $display("FAIL async_reset_clear: got %b want 0000000",
               {bus.level, bus.rise, bus.fall, bus.changed});
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.level, bus.rise, bus.fall, bus.changed} !== 7'b0) begin
      errors++;
      $display("FAIL async_reset_hold: got %b want 0000000",
               {bus.level, bus.rise, bus.fall, bus.changed});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick(2'b10, "post_reset", r, f);
      if (r[1]) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (first != CM + 1 || pulses != 1) begin
      errors++;
      $display("FAIL async_reset_requalify: got edge=%0d pulses=%0d want %0d 1", first, pulses, CM + 1);
    end
  endtask

  task automatic test_random();
    logic [1:0] r, f, raw;
    int len;
    apply_reset();
    for (int s = 0; s < 300; s++) begin
      raw = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) tick(raw, "random", r, f);
    end
  endtask

  initial begin
    bus.raw_in = 2'b01;
    model_reset();
    test_reset();
    test_rise_ch1();
    test_active_low();
    test_bounce();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
